// File: rtl/lpc_host_arbiter.sv
// Round-robin arbiter/sequencer for the LPC host control port.
// Optional busy-phase timeout: define LPC_ARB_TIMEOUT_EN.
module lpc_host_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int LFRAME_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_write_i,
  input  logic [NUM_REQ-1:0]   req_memory_i,
  input  logic [16*NUM_REQ-1:0] req_addr_i,
  input  logic [8*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   resp_valid_o,
  output logic [7:0]           resp_rdata_o,
  output logic                 resp_error_o,
  output logic [15:0]          host_addr_o,
  output logic [7:0]           host_data_o,
  output logic                 host_lframe_o,
  output logic                 host_rd_status_o,
  output logic                 host_wr_status_o,
  output logic                 host_memory_cycle_o,
  output logic                 host_nrst_o,
  input  logic [7:0]           host_data_i,
  input  logic                 host_ready_i,
  output logic                 busy_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0] LP_NR = (PW+1)'(NUM_REQ);
  localparam int LW = $clog2(LFRAME_CYCLES + 1);
  localparam logic [LW-1:0] LP_LF_LAST = LW'(LFRAME_CYCLES - 1);
`ifdef LPC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LP_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] r_gnt_oh;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [7:0]         r_rdata;
  logic [15:0]        r_addr;
  logic [7:0]         r_data;
  logic               r_lframe;
  logic               r_rd;
  logic               r_wr;
  logic               r_mem;
  logic               r_nrst;
  logic               r_busy;
  logic [LW-1:0]      r_lf_cnt;
`ifdef LPC_ARB_TIMEOUT_EN
  logic [TW-1:0]      r_to_cnt;
  logic               r_error;
`endif

  logic [NUM_REQ-1:0] w_rot;
  logic [PW-1:0]      w_off;
  logic [PW:0]        w_sum;
  logic [PW-1:0]      w_gnt;
  logic [PW:0]        w_nxt_sum;
  logic [PW-1:0]      w_nxt;
  logic               w_any;

  // Pick the first valid requester at or after the pointer, wrapping.
  always_comb begin
    w_rot = NUM_REQ'({req_valid_i, req_valid_i} >> r_ptr);
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = PW'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_gnt = (w_sum >= LP_NR) ? PW'(w_sum - LP_NR)
                             : w_sum[PW-1:0];
    w_nxt_sum = {1'b0, w_gnt} + 1'b1;
    w_nxt = (w_nxt_sum >= LP_NR) ? '0 : w_nxt_sum[PW-1:0];
    w_any = |req_valid_i;
  end

  // Cycle sequencer: grant, lframe strobe, busy handshake, response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_gnt_oh     <= '0;
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_rdata      <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_lframe     <= 1'b1;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_mem        <= 1'b0;
      r_nrst       <= 1'b0;
      r_busy       <= 1'b0;
      r_lf_cnt     <= '0;
`ifdef LPC_ARB_TIMEOUT_EN
      r_to_cnt     <= '0;
      r_error      <= 1'b0;
`endif
    end else begin
      r_nrst       <= 1'b1;
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (host_ready_i && w_any) begin
            r_req_ready <= NUM_REQ'(1) << w_gnt;
            r_gnt_oh    <= NUM_REQ'(1) << w_gnt;
            r_addr      <= req_addr_i[16*w_gnt +: 16];
            r_data      <= req_wdata_i[8*w_gnt +: 8];
            r_wr        <= req_write_i[w_gnt];
            r_rd        <= ~req_write_i[w_gnt];
            r_mem       <= req_memory_i[w_gnt];
            r_ptr       <= w_nxt;
            r_lframe    <= 1'b0;
            r_lf_cnt    <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (r_lf_cnt == LP_LF_LAST) begin
            r_lframe <= 1'b1;
            r_state  <= S_WAIT_BUSY;
`ifdef LPC_ARB_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end else begin
            r_lf_cnt <= r_lf_cnt + 1'b1;
          end
        end
        S_WAIT_BUSY: begin
          if (!host_ready_i) begin
            r_state  <= S_WAIT_DONE;
`ifdef LPC_ARB_TIMEOUT_EN
            r_to_cnt <= '0;
          end else if (r_to_cnt == LP_TO_LAST) begin
            r_state      <= S_RESP;
            r_resp_valid <= r_gnt_oh;
            r_error      <= 1'b1;
            r_rdata      <= 8'hFF;
            r_nrst       <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
`endif
          end
        end
        S_WAIT_DONE: begin
          if (host_ready_i) begin
            if (r_rd) r_rdata <= host_data_i;
            r_resp_valid <= r_gnt_oh;
            r_state      <= S_RESP;
`ifdef LPC_ARB_TIMEOUT_EN
          end else if (r_to_cnt == LP_TO_LAST) begin
            r_state      <= S_RESP;
            r_resp_valid <= r_gnt_oh;
            r_error      <= 1'b1;
            r_rdata      <= 8'hFF;
            r_nrst       <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`ifdef LPC_ARB_TIMEOUT_EN
          r_error <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o         = r_req_ready;
  assign resp_valid_o        = r_resp_valid;
  assign resp_rdata_o        = r_rdata;
  assign host_addr_o         = r_addr;
  assign host_data_o         = r_data;
  assign host_lframe_o       = r_lframe;
  assign host_rd_status_o    = r_rd;
  assign host_wr_status_o    = r_wr;
  assign host_memory_cycle_o = r_mem;
  assign host_nrst_o         = r_nrst;
  assign busy_o              = r_busy;
`ifdef LPC_ARB_TIMEOUT_EN
  assign resp_error_o        = r_error;
`else
  assign resp_error_o        = 1'b0;
`endif

endmodule

// File: tb/tb_lpc_host_arbiter.sv
// Self-checking bench for lpc_host_arbiter.
// Directed steps plus random traffic against a round-robin model.
module tb_lpc_host_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_write_i;
  logic [N-1:0]   req_memory_i;
  logic [16*N-1:0] req_addr_i;
  logic [8*N-1:0] req_wdata_i;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   resp_valid_o;
  logic [7:0]     resp_rdata_o;
  logic           resp_error_o;
  logic [15:0]    host_addr_o;
  logic [7:0]     host_data_o;
  logic           host_lframe_o;
  logic           host_rd_status_o;
  logic           host_wr_status_o;
  logic           host_memory_cycle_o;
  logic           host_nrst_o;
  logic [7:0]     host_data_i;
  logic           host_ready_i;
  logic           busy_o;

  lpc_host_arbiter #(
    .NUM_REQ(N),
    .LFRAME_CYCLES(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid_i),
    .req_write_i(req_write_i),
    .req_memory_i(req_memory_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o),
    .resp_error_o(resp_error_o),
    .host_addr_o(host_addr_o),
    .host_data_o(host_data_o),
    .host_lframe_o(host_lframe_o),
    .host_rd_status_o(host_rd_status_o),
    .host_wr_status_o(host_wr_status_o),
    .host_memory_cycle_o(host_memory_cycle_o),
    .host_nrst_o(host_nrst_o),
    .host_data_i(host_data_i),
    .host_ready_i(host_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // requester-side command state, one entry per requester
  bit          v [N];
  bit          w [N];
  bit          mm[N];
  logic [15:0] a [N];
  logic [7:0]  d [N];

  // model state
  int          m_ptr;
  logic [7:0]  m_rdata;

  int n_chk;
  int n_fail;

  always_comb begin
    req_valid_i  = '0;
    req_write_i  = '0;
    req_memory_i = '0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    for (int k = 0; k < N; k++) begin
      req_valid_i[k]      = v[k];
      req_write_i[k]      = w[k];
      req_memory_i[k]     = mm[k];
      req_addr_i[16*k+:16] = a[k];
      req_wdata_i[8*k+:8]  = d[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, want);
    end
  endtask

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic rand_cmd(input int k);
    w[k]  = 1'($urandom_range(0, 1));
    mm[k] = 1'($urandom_range(0, 1));
    a[k]  = 16'($urandom);
    d[k]  = 8'($urandom);
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) v[k] = 1'b0;
  endtask

  task automatic run_txn(input bit keep, input int wb,
                         input int wd, input logic [7:0] hd);
    int g;
    logic [15:0] ea;
    logic [7:0]  ed;
    bit ew, em;
    g = pick();
    if (g < 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL pick obs=none exp=valid");
      return;
    end
    ea = a[g]; ed = d[g]; ew = w[g]; em = mm[g];
    tick();
    chk("grant", 32'(req_ready_o), 32'(1 << g));
    chk("addr", 32'(host_addr_o), 32'(ea));
    chk("wdata", 32'(host_data_o), 32'(ed));
    chk("wr", 32'(host_wr_status_o), 32'(ew));
    chk("rd", 32'(host_rd_status_o), 32'(!ew));
    chk("mem", 32'(host_memory_cycle_o), 32'(em));
    chk("lframe0", 32'(host_lframe_o), 0);
    chk("busy", 32'(busy_o), 1);
    m_ptr = (g + 1) % N;
    if (keep) rand_cmd(g);
    else v[g] = 1'b0;
    tick();
    chk("ready_pulse", 32'(req_ready_o), 0);
    chk("lframe1", 32'(host_lframe_o), 0);
    tick();
    chk("lframe_end", 32'(host_lframe_o), 1);
    repeat (wb) begin
      tick();
      chk("wb_resp", 32'(resp_valid_o), 0);
    end
    host_ready_i = 1'b0;
    tick();
    repeat (wd) begin
      tick();
      chk("wd_addr", 32'(host_addr_o), 32'(ea));
      chk("wd_resp", 32'(resp_valid_o), 0);
    end
    host_data_i  = hd;
    host_ready_i = 1'b1;
    tick();
    if (!ew) m_rdata = hd;
    chk("resp_valid", 32'(resp_valid_o), 32'(1 << g));
    chk("rdata", 32'(resp_rdata_o), 32'(m_rdata));
    chk("err", 32'(resp_error_o), 0);
    chk("stat_hold",
        32'({host_rd_status_o, host_wr_status_o}),
        32'({!ew, ew}));
    tick();
    chk("resp_end", 32'(resp_valid_o), 0);
    chk("ready_gap", 32'(req_ready_o), 0);
    chk("rdwr_clr",
        32'({host_rd_status_o, host_wr_status_o}), 0);
    chk("idle_busy", 32'(busy_o), 0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_lframe"}, 32'(host_lframe_o), 1);
    chk({pfx, "_nrst"}, 32'(host_nrst_o), 0);
    chk({pfx, "_addr"}, 32'(host_addr_o), 0);
    chk({pfx, "_data"}, 32'(host_data_o), 0);
    chk({pfx, "_stat"},
        32'({host_rd_status_o, host_wr_status_o,
             host_memory_cycle_o}), 0);
    chk({pfx, "_ready"}, 32'(req_ready_o), 0);
    chk({pfx, "_resp"}, 32'(resp_valid_o), 0);
    chk({pfx, "_rdata"}, 32'(resp_rdata_o), 0);
    chk({pfx, "_err"}, 32'(resp_error_o), 0);
    chk({pfx, "_busy"}, 32'(busy_o), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    n_chk = 0;
    n_fail = 0;
    m_ptr = 0;
    m_rdata = 8'h00;
    rst = 1'b1;
    host_ready_i = 1'b1;
    host_data_i = 8'h00;
    for (int k = 0; k < N; k++) begin
      v[k] = 0; w[k] = 0; mm[k] = 0; a[k] = '0; d[k] = '0;
    end

    tick();
    tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();
    chk("nrst_rel", 32'(host_nrst_o), 1);
    chk("idle_lframe", 32'(host_lframe_o), 1);

    // single I/O write from requester 0
    v[0] = 1; w[0] = 1; mm[0] = 0;
    a[0] = 16'hF0F0; d[0] = 8'h5A;
    run_txn(1'b0, 1, 2, 8'h33);

    // single memory read from requester 1
    v[1] = 1; w[1] = 0; mm[1] = 1;
    a[1] = 16'h9696; d[1] = 8'h00;
    run_txn(1'b0, 0, 3, 8'hA5);

    // contention: both keep requesting, round-robin
    v[0] = 1; v[1] = 1;
    rand_cmd(0);
    rand_cmd(1);
    repeat (6) run_txn(1'b1, 0, 1, 8'($urandom));
    clear_reqs();

    // host busy in IDLE holds off the grant
    host_ready_i = 1'b0;
    v[0] = 1; rand_cmd(0);
    repeat (3) begin
      tick();
      chk("hold_ready", 32'(req_ready_o), 0);
      chk("hold_busy", 32'(busy_o), 0);
    end
    host_ready_i = 1'b1;
    run_txn(1'b0, 0, 1, 8'h6C);

    // request withdrawn before it could be granted
    host_ready_i = 1'b0;
    v[1] = 1; rand_cmd(1);
    tick();
    v[1] = 0;
    tick();
    host_ready_i = 1'b1;
    repeat (2) begin
      tick();
      chk("drop_ready", 32'(req_ready_o), 0);
    end

    // random traffic
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < N; k++) begin
        v[k] = 1'($urandom_range(0, 1));
        rand_cmd(k);
      end
      if (pick() < 0) v[$urandom_range(0, N-1)] = 1;
      run_txn(1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)),
              8'($urandom));
    end
    clear_reqs();
    tick();

    // reset while waiting for the host to finish
    v[0] = 1; rand_cmd(0);
    g = pick();
    tick();
    chk("mr_grant", 32'(req_ready_o), 32'(1 << g));
    v[g] = 0;
    tick();
    tick();
    host_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("mr");
    rst = 1'b0;
    host_ready_i = 1'b1;
    m_ptr = 0;
    m_rdata = 8'h00;
    tick();
    chk("mr_resp", 32'(resp_valid_o), 0);
    chk("mr_nrst", 32'(host_nrst_o), 1);
    v[1] = 1; rand_cmd(1);
    run_txn(1'b0, 1, 1, 8'h3C);

`ifdef LPC_ARB_TIMEOUT_EN
    // host never finishes: abort after the timeout budget
    v[0] = 1; rand_cmd(0); w[0] = 0;
    g = pick();
    tick();
    chk("to_grant", 32'(req_ready_o), 32'(1 << g));
    m_ptr = (g + 1) % N;
    v[g] = 0;
    host_ready_i = 1'b0;
    tick();
    tick();
    tick();
    repeat (TO - 1) begin
      tick();
      chk("to_wait", 32'(resp_valid_o), 0);
    end
    tick();
    m_rdata = 8'hFF;
    chk("to_resp", 32'(resp_valid_o), 32'(1 << g));
    chk("to_err", 32'(resp_error_o), 1);
    chk("to_rdata", 32'(resp_rdata_o), 32'(m_rdata));
    chk("to_nrst", 32'(host_nrst_o), 0);
    tick();
    chk("to_nrst_rel", 32'(host_nrst_o), 1);
    chk("to_err_clr", 32'(resp_error_o), 0);
    host_ready_i = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
